// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// The optional statistics counters are enabled with the RAM_ARB_STATS_EN macro.
package ram_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_RESP, ARB_DONE} arb_state_t;

    typedef logic arb_id_t;

    localparam int ARB_NPORTS     = 2;
    localparam int ARB_STAT_W     = 16;
    localparam int ARB_LOCK_CNT_W = 8;

    localparam logic [ARB_STAT_W-1:0] ARB_STAT_ONE = ARB_STAT_W'(1);

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Combinational owner selection: lock stickiness first, then round-robin.
module ram_arb_rr_pick
    import ram_arb_pkg::*;
(
    input  logic [ARB_NPORTS-1:0] req_i,
    input  arb_id_t               rr_ptr_i,
    input  arb_id_t               lock_owner_i,
    input  logic                  lock_active_i,
    output logic                  valid_o,
    output arb_id_t               winner_o
);

    always_comb begin
        valid_o  = 1'b0;
        winner_o = lock_owner_i;
        // A held lock blocks the other port even while the owner is silent.
        if (lock_active_i) begin
            valid_o = req_i[lock_owner_i];
        end else if (&req_i) begin
            valid_o  = 1'b1;
            winner_o = ~rr_ptr_i;
        end else if (req_i[1]) begin
            valid_o  = 1'b1;
            winner_o = 1'b1;
        end else if (req_i[0]) begin
            valid_o  = 1'b1;
            winner_o = 1'b0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-ported RAM between CPU (port 0) and loader/DMA (port 1), one op in flight.
// Define RAM_ARB_STATS_EN to add saturating grant/wait counters.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] phRamAddress,
    output logic [DATA_W-1:0] phRamWrite,
    output logic              phReadReq,
    output logic              phWriteReq,
    input  logic [DATA_W-1:0] phRamRead,
    output logic              grant_id,
`ifdef RAM_ARB_STATS_EN
    output logic [ARB_STAT_W-1:0] stat_grants0,
    output logic [ARB_STAT_W-1:0] stat_grants1,
    output logic [ARB_STAT_W-1:0] stat_wait1,
`endif
    output arb_state_t        dbg_state
);

    localparam logic [ARB_LOCK_CNT_W:0] LOCK_LIM = (ARB_LOCK_CNT_W+1)'(LOCK_MAX);

    arb_state_t                state_q, state_d;
    arb_id_t                   owner_q, owner_d;
    arb_id_t                   rr_q, rr_d;
    logic                      we_q, we_d;
    logic                      lk_q, lk_d;
    logic                      lock_act_q, lock_act_d;
    logic [ARB_LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic [DATA_W-1:0]         rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                      rd_stb_q, rd_stb_d, wr_stb_q, wr_stb_d;
    logic                      ack0_q, ack0_d, ack1_q, ack1_d;
    logic                      pick_valid;
    arb_id_t                   pick_winner;

    ram_arb_rr_pick u_pick (
        .req_i         ({m1_req, m0_req}),
        .rr_ptr_i      (rr_q),
        .lock_owner_i  (owner_q),
        .lock_active_i (lock_act_q),
        .valid_o       (pick_valid),
        .winner_o      (pick_winner)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        we_d       = we_q;
        lk_d       = lk_q;
        lock_act_d = lock_act_q;
        lock_cnt_d = lock_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        rd_stb_d   = 1'b0;
        wr_stb_d   = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = ARB_ISSUE;
                    owner_d  = pick_winner;
                    rr_d     = pick_winner;
                    we_d     = pick_winner ? m1_we    : m0_we;
                    lk_d     = pick_winner ? m1_lock  : m0_lock;
                    addr_d   = pick_winner ? m1_addr  : m0_addr;
                    wdata_d  = pick_winner ? m1_wdata : m0_wdata;
                    rd_stb_d = pick_winner ? ~m1_we   : ~m0_we;
                    wr_stb_d = pick_winner ? m1_we    : m0_we;
                end
            end
            ARB_ISSUE: state_d = ARB_RESP;
            ARB_RESP: begin
                state_d = ARB_DONE;
                if (!we_q) begin
                    if (owner_q) rdata1_d = phRamRead;
                    else         rdata0_d = phRamRead;
                end
                ack0_d = ~owner_q;
                ack1_d = owner_q;
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
                // lock_cnt_q counts completed ops in the current locked run.
                if (lk_q && (({1'b0, lock_cnt_q} + 1'b1) < LOCK_LIM)) begin
                    lock_act_d = 1'b1;
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end else begin
                    lock_act_d = 1'b0;
                    lock_cnt_d = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= 1'b0;
            rr_q       <= 1'b1;
            we_q       <= 1'b0;
            lk_q       <= 1'b0;
            lock_act_q <= 1'b0;
            lock_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rd_stb_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            we_q       <= we_d;
            lk_q       <= lk_d;
            lock_act_q <= lock_act_d;
            lock_cnt_q <= lock_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rd_stb_q   <= rd_stb_d;
            wr_stb_q   <= wr_stb_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
        end
    end

    assign m0_ack       = ack0_q;
    assign m1_ack       = ack1_q;
    assign m0_rdata     = rdata0_q;
    assign m1_rdata     = rdata1_q;
    assign phRamAddress = addr_q;
    assign phRamWrite   = wdata_q;
    assign phReadReq    = rd_stb_q;
    assign phWriteReq   = wr_stb_q;
    assign grant_id     = owner_q;
    assign dbg_state    = state_q;

`ifdef RAM_ARB_STATS_EN
    logic [ARB_STAT_W-1:0] st_g0_q, st_g1_q, st_w1_q;
    logic                  wait1;

    // Port 1 is waiting whenever it requests and does not own an op in flight.
    assign wait1 = m1_req && !((state_q != ARB_IDLE) && owner_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_g0_q <= '0;
            st_g1_q <= '0;
            st_w1_q <= '0;
        end else begin
            if (ack0_q && (st_g0_q != '1)) st_g0_q <= st_g0_q + ARB_STAT_ONE;
            if (ack1_q && (st_g1_q != '1)) st_g1_q <= st_g1_q + ARB_STAT_ONE;
            if (wait1  && (st_w1_q != '1)) st_w1_q <= st_w1_q + ARB_STAT_ONE;
        end
    end

    assign stat_grants0 = st_g0_q;
    assign stat_grants1 = st_g1_q;
    assign stat_wait1   = st_w1_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed plus randomized bench for ram_port_arbiter with a transaction-level reference model.
// Stats checks are compiled in when RAM_ARB_STATS_EN is defined.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 8;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lock;
    } op_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic              m0_ack, m1_ack;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] phRamAddress;
    logic [DATA_W-1:0] phRamWrite;
    logic              phReadReq, phWriteReq;
    logic [DATA_W-1:0] phRamRead = '0;
    logic              grant_id;
    arb_state_t        dbg_state;
`ifdef RAM_ARB_STATS_EN
    logic [ARB_STAT_W-1:0] stat_grants0, stat_grants1, stat_wait1;
`endif

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_lock      (m0_lock),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_ack       (m0_ack),
        .m0_rdata     (m0_rdata),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_lock      (m1_lock),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_ack       (m1_ack),
        .m1_rdata     (m1_rdata),
        .phRamAddress (phRamAddress),
        .phRamWrite   (phRamWrite),
        .phReadReq    (phReadReq),
        .phWriteReq   (phWriteReq),
        .phRamRead    (phRamRead),
        .grant_id     (grant_id),
`ifdef RAM_ARB_STATS_EN
        .stat_grants0 (stat_grants0),
        .stat_grants1 (stat_grants1),
        .stat_wait1   (stat_wait1),
`endif
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- RAM device seen by the DUT ----------------
    logic [7:0] ram [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] dflt_byte(input logic [31:0] a);
        return a[7:0] ^ 8'hC3;
    endfunction

    always @(posedge clk) begin
        if (phWriteReq) begin
            for (int i = 0; i < 4; i++) ram[phRamAddress + 32'(i)] = phRamWrite[8*i +: 8];
        end
        if (phReadReq) begin
            for (int i = 0; i < 4; i++) begin
                if (ram.exists(phRamAddress + 32'(i))) phRamRead[8*i +: 8] <= ram[phRamAddress + 32'(i)];
                else                                    phRamRead[8*i +: 8] <= dflt_byte(phRamAddress + 32'(i));
            end
        end
    end

    // ---------------- reference model state ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    op_t         q0[$], q1[$];
    bit          busy = 1'b0;
    int          dec_cyc = 0;
    bit          m_owner = 1'b0;
    bit          rr_m = 1'b1;
    bit          hold = 1'b0;
    int          streak = 0;
    op_t         m_op;
    logic [31:0] pred_rd = '0;
    logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
    bit          exp_gid = 1'b0;
    bit          order[$];
    int          g0_m = 0, g1_m = 0, w1_m = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            if (ref_mem.exists(a + 32'(i))) w[8*i +: 8] = ref_mem[a + 32'(i)];
            else                             w[8*i +: 8] = dflt_byte(a + 32'(i));
        end
        return w;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            ram[a + 32'(i)]     = w[8*i +: 8];
            ref_mem[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    function automatic op_t mk_op(input logic we, input logic [31:0] a, input logic [31:0] d, input logic lk);
        op_t o;
        o.we = we; o.addr = a; o.wdata = d; o.lock = lk;
        return o;
    endfunction

    task automatic drive();
        if (q0.size() > 0) begin
            m0_req = 1'b1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata; m0_lock = q0[0].lock;
        end else begin
            m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0;
        end
        if (q1.size() > 0) begin
            m1_req = 1'b1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata; m1_lock = q1[0].lock;
        end else begin
            m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0;
        end
    endtask

    // Arbitration decision for the idle cycle: the DUT samples these requests at the next edge.
    task automatic decide();
        bit r0, r1, got, w;
        r0 = (q0.size() > 0);
        r1 = (q1.size() > 0);
        got = 1'b0;
        w = 1'b0;
        if (hold) begin
            if (m_owner ? r1 : r0) begin got = 1'b1; w = m_owner; end
        end else if (r0 && r1) begin
            got = 1'b1; w = ~rr_m;
        end else if (r0) begin
            got = 1'b1; w = 1'b0;
        end else if (r1) begin
            got = 1'b1; w = 1'b1;
        end
        if (got) begin
            busy = 1'b1; dec_cyc = cyc; m_owner = w; rr_m = w;
            m_op = w ? q1[0] : q0[0];
            if (m_op.we) begin
                for (int i = 0; i < 4; i++) ref_mem[m_op.addr + 32'(i)] = m_op.wdata[8*i +: 8];
            end else begin
                pred_rd = ref_read(m_op.addr);
            end
        end else begin
            busy = 1'b0;
        end
    endtask

    task automatic step();
        bit strobe, ackc;
        @(posedge clk);
        #1;
        cyc++;
        strobe = busy && (cyc == dec_cyc + 1);
        ackc   = busy && (cyc == dec_cyc + 3);
        if (strobe) exp_gid = m_owner;
        if (ackc && !m_op.we) begin
            if (m_owner) exp_rd1 = pred_rd;
            else         exp_rd0 = pred_rd;
        end
        chk1("rd_strobe", phReadReq, strobe && !m_op.we);
        chk1("wr_strobe", phWriteReq, strobe && m_op.we);
        if (strobe) begin
            chk32("ram_addr", phRamAddress, m_op.addr);
            if (m_op.we) chk32("ram_wdata", phRamWrite, m_op.wdata);
        end
        chk1("m0_ack", m0_ack, ackc && !m_owner);
        chk1("m1_ack", m1_ack, ackc && m_owner);
        chk32("m0_rdata", m0_rdata, exp_rd0);
        chk32("m1_rdata", m1_rdata, exp_rd1);
        chk1("grant_id", grant_id, exp_gid);
        if (ackc) begin
            order.push_back(m_owner);
            if (m_owner) begin g1_m++; void'(q1.pop_front()); end
            else         begin g0_m++; void'(q0.pop_front()); end
            streak = hold ? streak + 1 : 1;
            hold = m_op.lock && (streak < LOCK_MAX);
            if (!hold) streak = 0;
        end
        drive();
        if (m1_req && !(busy && cyc >= dec_cyc + 1 && cyc <= dec_cyc + 3 && m_owner)) w1_m++;
        if (!busy || cyc >= dec_cyc + 4) decide();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || (busy && cyc < dec_cyc + 4)) && n < max_cyc) begin
            step();
            n++;
        end
        chk1("drain_timeout", n < max_cyc, 1'b1);
        step();
        step();
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete(); order.delete();
        busy = 1'b0; m_owner = 1'b0; rr_m = 1'b1; hold = 1'b0; streak = 0;
        exp_rd0 = '0; exp_rd1 = '0; exp_gid = 1'b0;
        g0_m = 0; g1_m = 0; w1_m = 0;
        drive();
    endtask

    task automatic check_reset_vals(input string tag);
        chk1({tag, "_rd_strobe"}, phReadReq, 1'b0);
        chk1({tag, "_wr_strobe"}, phWriteReq, 1'b0);
        chk1({tag, "_m0_ack"}, m0_ack, 1'b0);
        chk1({tag, "_m1_ack"}, m1_ack, 1'b0);
        chk32({tag, "_m0_rdata"}, m0_rdata, 32'h0);
        chk32({tag, "_m1_rdata"}, m1_rdata, 32'h0);
        chk32({tag, "_addr"}, phRamAddress, 32'h0);
        chk32({tag, "_wdata"}, phRamWrite, 32'h0);
        chk1({tag, "_grant_id"}, grant_id, 1'b0);
        chk32({tag, "_state"}, 32'(dbg_state), 32'(ARB_IDLE));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1 check_reset_vals("reset");
    endtask

    initial begin
        logic [31:0] saved_rd1;
        int          wait_n;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1 check_reset_vals("reset");

        // Single port-0 read, little-endian assembly
        preload(32'h100, 32'h44332211);
        q0.push_back(mk_op(1'b0, 32'h100, 32'h0, 1'b0));
        run_until_idle(40);
        chk32("s1_rdata", m0_rdata, 32'h44332211);
        chk32("s1_order_len", 32'(order.size()), 32'd1);

        // Simultaneous requests after reset: port 0 first, then strict alternation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            preload(32'h180 + 32'(8*i), $urandom);
            preload(32'h1C0 + 32'(8*i), $urandom);
            q0.push_back(mk_op(1'b0, 32'h180 + 32'(8*i), 32'h0, 1'b0));
            q1.push_back(mk_op(1'b0, 32'h1C0 + 32'(8*i), 32'h0, 1'b0));
        end
        run_until_idle(100);
        chk32("s2_order_len", 32'(order.size()), 32'd8);
        if (order.size() == 8) begin
            for (int i = 0; i < 8; i++) chk1($sformatf("s2_order%0d", i), order[i], 1'(i % 2));
        end
`ifdef RAM_ARB_STATS_EN
        chk32("stat_grants0", 32'(stat_grants0), 32'd4);
        chk32("stat_grants1", 32'(stat_grants1), 32'd4);
        chk32("stat_wait1_model", 32'(stat_wait1), 32'(w1_m));
        chk1("stat_wait1_nonzero", stat_wait1 != '0, 1'b1);
`endif

        // Port 1 write then port 0 read of the same word
        saved_rd1 = exp_rd1;
        q1.push_back(mk_op(1'b1, 32'h200, 32'hDEADBEEF, 1'b0));
        run_until_idle(40);
        q0.push_back(mk_op(1'b0, 32'h200, 32'h0, 1'b0));
        run_until_idle(40);
        chk32("s3_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk32("s3_m1_rdata_kept", m1_rdata, saved_rd1);

        // Locked run by port 0 is capped at LOCK_MAX ops
        order.delete();
        for (int i = 0; i < 10; i++) q0.push_back(mk_op(1'(i % 3 == 0), 32'h240 + 32'(4*i), $urandom, 1'(i != 9)));
        step();
        q1.push_back(mk_op(1'b0, 32'h300, 32'h0, 1'b0));
        q1.push_back(mk_op(1'b1, 32'h304, 32'h12345678, 1'b0));
        run_until_idle(200);
        chk32("s4_order_len", 32'(order.size()), 32'd12);
        if (order.size() >= 9) begin
            for (int i = 0; i < 8; i++) chk1($sformatf("s4_locked%0d", i), order[i], 1'b0);
            chk1("s4_release", order[8], 1'b1);
        end

        // Randomized mix of reads, writes and locked runs from both ports
        order.delete();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 20; i++) begin
                op_t o;
                o = mk_op(1'($urandom_range(0, 1)), 32'h400 + 32'($urandom_range(0, 31)), $urandom,
                          1'(($urandom_range(0, 9) < 3) && (i != 19)));
                if (p == 0) q0.push_back(o);
                else        q1.push_back(o);
            end
        end
        run_until_idle(600);
        chk32("rand_order_len", 32'(order.size()), 32'd40);

        // Reset while a read strobe is on the RAM bus
        q0.push_back(mk_op(1'b0, 32'h100, 32'h0, 1'b0));
        wait_n = 0;
        while (!(busy && cyc == dec_cyc + 1) && wait_n < 10) begin
            step();
            wait_n++;
        end
        chk1("s5_reach_issue", wait_n < 10, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk1("s5_rd_strobe_async", phReadReq, 1'b0);
        chk1("s5_wr_strobe_async", phWriteReq, 1'b0);
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk1("s5_no_ack0", m0_ack, 1'b0);
            chk1("s5_no_ack1", m1_ack, 1'b0);
        end
        #2 reset_n = 1'b1;
        #1 check_reset_vals("s5_release");
        q0.push_back(mk_op(1'b0, 32'h100, 32'h0, 1'b0));
        run_until_idle(40);
        chk32("s5_after_rdata", m0_rdata, 32'h44332211);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
